// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter
//   Serialises 68K and Z80 accesses to the single-port sound shared RAM.
//   One access is in flight at a time; the 68K gets DTACK, the Z80 gets WAIT.
//   Optional build macro: SHARED_RAM_Z80_PRIO_EN. When it is defined, the Z80 always wins
//   a simultaneous request and no last-grant state exists. When it is undefined, ties
//   alternate (round-robin).
module shared_ram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m68k_cs,
  input  logic              m68k_rw,
  input  logic              m68k_lds_n,
  input  logic [ADDR_W-1:0] m68k_addr,
  input  logic [DATA_W-1:0] m68k_din,
  output logic [DATA_W-1:0] m68k_dout,
  output logic              m68k_dtack_n,
  input  logic              z80_cs,
  input  logic              z80_rd_n,
  input  logic              z80_wr_n,
  input  logic [ADDR_W-1:0] z80_addr,
  input  logic [DATA_W-1:0] z80_din,
  output logic [DATA_W-1:0] z80_dout,
  output logic              z80_wait_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT_68K,
    S_GNT_Z80,
    S_WAIT_RD,
    S_ACK
  } state_t;

  // Final count value of the read-wait counter; RD_LAT is 1 or 2.
  localparam logic [1:0] LP_CNT_LAST = 2'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_state_next;

  logic              r_owner_z80;
  logic              w_owner_z80_next;
  logic              r_is_rd;
  logic              w_is_rd_next;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_next;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W-1:0] w_ram_addr_next;
  logic [DATA_W-1:0] r_ram_din;
  logic [DATA_W-1:0] w_ram_din_next;
  logic              r_ram_we;
  logic              w_ram_we_next;
  logic [DATA_W-1:0] r_m68k_dout;
  logic [DATA_W-1:0] w_m68k_dout_next;
  logic [DATA_W-1:0] r_z80_dout;
  logic [DATA_W-1:0] w_z80_dout_next;
  logic              r_m68k_done;
  logic              w_m68k_done_next;
  logic              r_z80_done;
  logic              w_z80_done_next;
  logic              r_m68k_dtack_n;
  logic              w_m68k_dtack_n_next;
  logic              w_enter_ack;

  logic              w_m68k_req;
  logic              w_z80_req;
  logic              w_pick_z80;

  // A select is served once; the done flag masks it until the select drops.
  assign w_m68k_req = m68k_cs & ~r_m68k_done;
  assign w_z80_req  = z80_cs & (~z80_rd_n | ~z80_wr_n) & ~r_z80_done;

`ifdef SHARED_RAM_Z80_PRIO_EN
  // Sound timing matters most: the Z80 wins every tie.
  assign w_pick_z80 = w_z80_req;
`else
  logic r_last_z80;
  logic w_last_z80_next;
  logic w_tie;

  assign w_tie      = w_m68k_req & w_z80_req;
  // On a tie, grant the side that lost the previous tie.
  assign w_pick_z80 = w_z80_req & (~w_m68k_req | ~r_last_z80);

  // Remember only tie outcomes. A grant that follows a lost tie is not a tie,
  // so it must not flip the round-robin pointer back.
  always_comb begin
    w_last_z80_next = r_last_z80;
    if ((r_state == S_IDLE) && w_tie) begin
      w_last_z80_next = w_pick_z80;
    end
  end

  // Register the tie-break pointer; after reset the Z80 counts as last granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_z80 <= 1'b1;
    end else begin
      r_last_z80 <= w_last_z80_next;
    end
  end
`endif

  // Next-state and datapath decode for the access sequencer.
  always_comb begin
    w_state_next        = r_state;
    w_owner_z80_next    = r_owner_z80;
    w_is_rd_next        = r_is_rd;
    w_cnt_next          = r_cnt;
    w_ram_addr_next     = r_ram_addr;
    w_ram_din_next      = r_ram_din;
    w_ram_we_next       = 1'b0;
    w_m68k_dout_next    = r_m68k_dout;
    w_z80_dout_next     = r_z80_dout;
    w_m68k_done_next    = r_m68k_done;
    w_z80_done_next     = r_z80_done;
    w_m68k_dtack_n_next = r_m68k_dtack_n;
    w_enter_ack         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_pick_z80) begin
          w_state_next     = S_GNT_Z80;
          w_owner_z80_next = 1'b1;
          w_is_rd_next     = z80_wr_n;
          w_ram_addr_next  = z80_addr;
          w_ram_din_next   = z80_din;
          w_ram_we_next    = ~z80_wr_n;
        end else if (w_m68k_req) begin
          w_state_next     = S_GNT_68K;
          w_owner_z80_next = 1'b0;
          w_is_rd_next     = m68k_rw;
          w_ram_addr_next  = m68k_addr;
          w_ram_din_next   = m68k_din;
          // Only the low byte lives here; an upper-byte-only write is acked but dropped.
          w_ram_we_next    = ~m68k_rw & ~m68k_lds_n;
        end
      end
      S_GNT_68K, S_GNT_Z80: begin
        if (r_is_rd) begin
          w_state_next = S_WAIT_RD;
          w_cnt_next   = 2'd0;
        end else begin
          w_state_next = S_ACK;
          w_enter_ack  = 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (r_cnt == LP_CNT_LAST) begin
          // A requester that gave up keeps its previous read data.
          if (r_owner_z80) begin
            if (z80_cs) begin
              w_z80_dout_next = ram_dout;
            end
          end else if (m68k_cs) begin
            w_m68k_dout_next = ram_dout;
          end
          w_state_next = S_ACK;
          w_enter_ack  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 2'd1;
        end
      end
      S_ACK: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Completion is flagged on entry to ACK so Z80 WAIT releases in the ACK cycle.
    if (w_enter_ack) begin
      if (!r_owner_z80 && m68k_cs) begin
        w_m68k_done_next    = 1'b1;
        w_m68k_dtack_n_next = 1'b0;
      end
      if (r_owner_z80 && z80_cs) begin
        w_z80_done_next = 1'b1;
      end
    end

    // Dropping a select always clears its handshake state.
    if (!m68k_cs) begin
      w_m68k_done_next    = 1'b0;
      w_m68k_dtack_n_next = 1'b1;
    end
    if (!z80_cs) begin
      w_z80_done_next = 1'b0;
    end
  end

  // State register; reset abandons any access immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and handshake registers; reset kills a pending write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_z80    <= 1'b0;
      r_is_rd        <= 1'b0;
      r_cnt          <= 2'd0;
      r_ram_addr     <= '0;
      r_ram_din      <= '0;
      r_ram_we       <= 1'b0;
      r_m68k_dout    <= '0;
      r_z80_dout     <= '0;
      r_m68k_done    <= 1'b0;
      r_z80_done     <= 1'b0;
      r_m68k_dtack_n <= 1'b1;
    end else begin
      r_owner_z80    <= w_owner_z80_next;
      r_is_rd        <= w_is_rd_next;
      r_cnt          <= w_cnt_next;
      r_ram_addr     <= w_ram_addr_next;
      r_ram_din      <= w_ram_din_next;
      r_ram_we       <= w_ram_we_next;
      r_m68k_dout    <= w_m68k_dout_next;
      r_z80_dout     <= w_z80_dout_next;
      r_m68k_done    <= w_m68k_done_next;
      r_z80_done     <= w_z80_done_next;
      r_m68k_dtack_n <= w_m68k_dtack_n_next;
    end
  end

  assign m68k_dout    = r_m68k_dout;
  assign m68k_dtack_n = r_m68k_dtack_n;
  assign z80_dout     = r_z80_dout;
  // WAIT follows the live request: it drops with the strobe and releases once done is set.
  assign z80_wait_n   = ~w_z80_req;
  assign ram_addr     = r_ram_addr;
  assign ram_din      = r_ram_din;
  assign ram_we       = r_ram_we;

endmodule
